// File: rtl/joy_db15_if.sv
// DB15 SNAC joystick link: host strobes and player states in, serial data and status out.
`timescale 1ns/1ps
interface joy_db15_if #(
    parameter int unsigned BITS_PER_PLAYER = 12
);
    localparam int unsigned IDX_W = $clog2(2 * BITS_PER_PLAYER);

    logic [BITS_PER_PLAYER-1:0] joy1;
    logic [BITS_PER_PLAYER-1:0] joy2;
    logic                       joy_clk_in;
    logic                       joy_load_in;
    logic                       joy_data_out;
    logic                       frame_done;
    logic [IDX_W-1:0]           bit_index;
    logic                       timeout_err;

    modport master (
        output joy1, joy2, joy_clk_in, joy_load_in,
        input  joy_data_out, frame_done, bit_index, timeout_err
    );

    modport slave (
        input  joy1, joy2, joy_clk_in, joy_load_in,
        output joy_data_out, frame_done, bit_index, timeout_err
    );
endinterface

// File: rtl/joy_db15_responder.sv
// Device-side DB15 SNAC responder: emulates the adapter's shift chain, serialising
// two player states (inverted, joy1[0] first) on the host's load/clock strobes.
`timescale 1ns/1ps
module joy_db15_responder #(
    parameter int unsigned BITS_PER_PLAYER = 12,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned TIMEOUT         = 65535
) (
    input  logic       clk,
    input  logic       reset,
    joy_db15_if.slave  bus
);
    localparam int unsigned FRAME_BITS = 2 * BITS_PER_PLAYER;
    localparam int unsigned IDX_W      = $clog2(FRAME_BITS);
    localparam int unsigned WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BITS - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic                   clk_prev;
    logic [FRAME_BITS-1:0]  shreg;
    logic [IDX_W-1:0]       idx_q;
    logic [WD_W-1:0]        wd_cnt;
    logic                   data_q;
    logic                   done_q;
    logic                   to_q;

    logic                   clk_rise;
    logic                   load_low;
    logic [FRAME_BITS-1:0]  snap;

    // Pin synchronisers preset high so reset release never looks like an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            load_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.joy_clk_in};
            load_sync <= {load_sync[SYNC_STAGES-2:0], bus.joy_load_in};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign clk_rise = clk_sync[SYNC_STAGES-1] & ~clk_prev;
    assign load_low = ~load_sync[SYNC_STAGES-1];
    assign snap     = ~{bus.joy2, bus.joy1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '1;
            idx_q  <= '0;
            wd_cnt <= '0;
            data_q <= 1'b1;
            done_q <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            to_q   <= 1'b0;
            if (wd_cnt != WD_MAX) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (clk_rise) begin
                wd_cnt <= '0;
            end

            // Load level wins over everything, including a coincident clock edge
            if (load_low) begin
                state  <= LOAD;
                shreg  <= snap;
                data_q <= snap[0];
                idx_q  <= '0;
            end else begin
                case (state)
                    IDLE: data_q <= 1'b1;
                    // Reaching here with load high is the load rising edge
                    LOAD: begin
                        state  <= SHIFT;
                        wd_cnt <= '0;
                    end
                    SHIFT: begin
                        if (clk_rise) begin
                            shreg <= {1'b1, shreg[FRAME_BITS-1:1]};
                            if (idx_q == LAST_IDX) begin
                                data_q <= 1'b1;
                                done_q <= 1'b1;
                                state  <= DONE;
                            end else begin
                                data_q <= shreg[1];
                                idx_q  <= idx_q + IDX_W'(1);
                            end
                        end else if (wd_cnt == WD_MAX) begin
                            state  <= IDLE;
                            shreg  <= '1;
                            data_q <= 1'b1;
                            to_q   <= 1'b1;
                        end
                    end
                    DONE: data_q <= 1'b1;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.joy_data_out = data_q;
    assign bus.frame_done   = done_q;
    assign bus.bit_index    = idx_q;
    assign bus.timeout_err  = to_q;
endmodule
